// File: rtl/barcode_pkg.sv
// Shared types and constants for the barcode station-ID receiver.
package barcode_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START_LOW = 2'd1,
      WAIT_FALL = 2'd2,
      SAMPLE    = 2'd3
   } state_t;

   localparam int CNT_W     = 22;
   localparam int ID_BITS   = 8;
   localparam int BIT_CNT_W = $clog2(ID_BITS);

   // Top two bits of a received byte must match this for the byte to be a station ID.
   localparam logic [1:0] VALID_MASK = 2'b00;

endpackage

// File: rtl/bc_edge_det.sv
// Two-flop synchronizer for the raw barcode line plus a third flop for falling-edge detection.
module bc_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic BC,
   output logic BC_sync,
   output logic BC_fall
);

   logic ff1, ff2, ff3;

   // Flops reset high so an idle line produces no spurious edge after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff1 <= 1'b1;
         ff2 <= 1'b1;
         ff3 <= 1'b1;
      end else begin
         ff1 <= BC;
         ff2 <= ff1;
         ff3 <= ff2;
      end
   end

   assign BC_sync = ff2;
   assign BC_fall = ff3 & ~ff2;

endmodule

// File: rtl/barcode.sv
// Barcode receiver: measures the start-period low time, samples 8 data bits at that point, publishes valid IDs.
module barcode
   import barcode_pkg::*;
#(
   parameter int CW = CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               BC,
   input  logic               clr_ID_vld,
   output logic [ID_BITS-1:0] ID,
   output logic               ID_vld
);

   logic                 bc_sync, bc_fall;
   state_t               state, nxt_state;
   logic [CW-1:0]        cnt, s_pt, timer;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [ID_BITS-1:0]   shift;
   logic                 done;

   logic start_clr, cnt_inc, s_load, timer_clr, timer_inc, sample, last_bit;
   logic id_load;

   bc_edge_det u_edge (
      .clk     (clk),
      .rst     (rst),
      .BC      (BC),
      .BC_sync (bc_sync),
      .BC_fall (bc_fall)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      case (state)
         IDLE:      if (bc_fall) nxt_state = START_LOW;
         // A zero count is a one-cycle glitch; a saturated count is a stuck line.
         START_LOW: if (bc_sync)       nxt_state = (cnt == '0) ? IDLE : WAIT_FALL;
                    else if (&cnt)     nxt_state = IDLE;
         WAIT_FALL: if (bc_fall) nxt_state = SAMPLE;
         SAMPLE:    if (timer == s_pt)
                       nxt_state = (bit_cnt == BIT_CNT_W'(ID_BITS - 1)) ? IDLE : WAIT_FALL;
         default:   nxt_state = IDLE;
      endcase
   end

   always_comb begin
      start_clr = (state == IDLE) && bc_fall;
      cnt_inc   = (state == START_LOW) && !bc_sync && !(&cnt);
      s_load    = (state == START_LOW) && bc_sync;
      timer_clr = (state == WAIT_FALL) && bc_fall;
      sample    = (state == SAMPLE) && (timer == s_pt);
      timer_inc = (state == SAMPLE) && (timer != s_pt);
      last_bit  = sample && (bit_cnt == BIT_CNT_W'(ID_BITS - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         s_pt    <= '0;
         timer   <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         done    <= 1'b0;
      end else begin
         if (start_clr)    cnt <= '0;
         else if (cnt_inc) cnt <= cnt + 1'b1;

         if (s_load) s_pt <= cnt;

         if (timer_clr)      timer <= '0;
         else if (timer_inc) timer <= timer + 1'b1;

         if (s_load)      bit_cnt <= '0;
         else if (sample) bit_cnt <= bit_cnt + 1'b1;

         if (start_clr)   shift <= '0;
         else if (sample) shift <= {shift[ID_BITS-2:0], bc_sync};

         done <= last_bit;
      end
   end

   assign id_load = done && (shift[ID_BITS-1:ID_BITS-2] == VALID_MASK);

   // A new ID takes priority over a consumer clear landing on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ID     <= '0;
         ID_vld <= 1'b0;
      end else begin
         if (id_load) ID <= shift;
         if (id_load)         ID_vld <= 1'b1;
         else if (clr_ID_vld) ID_vld <= 1'b0;
      end
   end

endmodule

// File: tb/tb_barcode.sv
// Directed bench for the barcode receiver; counter width shrunk so the stuck-low case stays short.
module tb_barcode;
   import barcode_pkg::*;

   localparam int TB_CW = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       BC;
   logic       clr_ID_vld;
   logic [7:0] ID;
   logic       ID_vld;

   int n_assert = 0;
   int n_fail   = 0;

   barcode #(.CW(TB_CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .BC         (BC),
      .clr_ID_vld (clr_ID_vld),
      .ID         (ID),
      .ID_vld     (ID_vld)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_start();
      BC = 1'b0; clks(100);
      BC = 1'b1; clks(100);
   endtask

   task automatic send_bit(input logic b);
      BC = 1'b0; clks(b ? 40 : 150);
      BC = 1'b1; clks(b ? 160 : 50);
   endtask

   task automatic send_frame(input logic [7:0] d);
      send_start();
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      clks(20);
   endtask

   task automatic pulse_clr();
      clr_ID_vld = 1'b1; clks(1);
      clr_ID_vld = 1'b0; clks(1);
   endtask

   initial begin
      logic [7:0] d;
      rst = 1'b1; BC = 1'b1; clr_ID_vld = 1'b0;
      clks(3);
      check("reset_id", ID, 8'h00);
      check("reset_vld", ID_vld, 1'b0);
      check("reset_state", dut.state, IDLE);
      rst = 1'b0;
      clks(5);

      // 8'h2D with a tight window on when ID_vld rises after the last falling edge
      d = 8'h2D;
      send_start();
      for (int i = 7; i >= 1; i--) send_bit(d[i]);
      BC = 1'b0; clks(40);
      BC = 1'b1; clks(60);
      check("2d_vld_early", ID_vld, 1'b0);
      clks(7);
      check("2d_vld", ID_vld, 1'b1);
      check("2d_id", ID, 8'h2D);
      clks(113);

      pulse_clr();
      check("clr_vld", ID_vld, 1'b0);

      send_frame(8'hC9);
      check("c9_id", ID, 8'h2D);
      check("c9_vld", ID_vld, 1'b0);

      send_frame(8'h09);
      check("09_id", ID, 8'h09);
      check("09_vld", ID_vld, 1'b1);
      pulse_clr();
      check("09_clr_vld", ID_vld, 1'b0);

      // single-cycle low is a glitch and must leave the receiver idle
      BC = 1'b0; clks(1);
      BC = 1'b1; clks(6);
      check("glitch_state", dut.state, IDLE);

      // clear lands on the same edge the ID is published
      d = 8'h12;
      send_start();
      for (int i = 7; i >= 1; i--) send_bit(d[i]);
      BC = 1'b0; clks(103);
      clr_ID_vld = 1'b1; clks(1);
      clr_ID_vld = 1'b0; clks(46);
      BC = 1'b1; clks(50);
      check("12_vld", ID_vld, 1'b1);
      check("12_id", ID, 8'h12);

      // reset in the middle of a frame
      d = 8'h2D;
      send_start();
      for (int i = 7; i >= 4; i--) send_bit(d[i]);
      rst = 1'b1; clks(2);
      rst = 1'b0; clks(2);
      check("rst_id", ID, 8'h00);
      check("rst_vld", ID_vld, 1'b0);
      send_frame(8'h05);
      check("05_id", ID, 8'h05);
      check("05_vld", ID_vld, 1'b1);
      pulse_clr();
      check("05_clr_vld", ID_vld, 1'b0);

      // line stuck low past counter saturation
      BC = 1'b0; clks(500);
      check("stall_mid_vld", ID_vld, 1'b0);
      clks(600);
      check("stall_state", dut.state, IDLE);
      check("stall_vld", ID_vld, 1'b0);
      check("stall_id", ID, 8'h05);
      BC = 1'b1; clks(50);
      send_frame(8'h11);
      check("11_id", ID, 8'h11);
      check("11_vld", ID_vld, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
